// File: rtl/relogio_pkg.sv
// Shared BCD types and helpers for the digital clock counters.
// Provides the digit type, the largest legal digit and digit-pair helpers.
package relogio_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic logic bcd_is_valid(input bcd_digit_t digit);
        return digit <= BCD_MAX_DIGIT;
    endfunction

    // Binary value of a digit pair; msd up to 15 still fits in 8 bits.
    function automatic logic [7:0] bcd_pair_to_int(input bcd_digit_t msd,
                                                   input bcd_digit_t lsd);
        return ({4'b0, msd} * 8'd10) + {4'b0, lsd};
    endfunction

endpackage

// File: rtl/cbm_passo_bcd.sv
// Combinational BCD stepper: next value of a two-digit count, one step
// up or down, wrapping between min and max (all given as BCD digit pairs).
// Ports: cur_* current digits, down direction, min_*/max_* range limits,
//        nxt_* next digits, wrap high when the step crosses the range end.
module cbm_passo_bcd
    import relogio_pkg::*;
(
    input  bcd_digit_t cur_msd,
    input  bcd_digit_t cur_lsd,
    input  logic       down,
    input  bcd_digit_t min_msd,
    input  bcd_digit_t min_lsd,
    input  bcd_digit_t max_msd,
    input  bcd_digit_t max_lsd,
    output bcd_digit_t nxt_msd,
    output bcd_digit_t nxt_lsd,
    output logic       wrap
);

    logic at_min;
    logic at_max;

    assign at_min = (cur_msd == min_msd) && (cur_lsd == min_lsd);
    assign at_max = (cur_msd == max_msd) && (cur_lsd == max_lsd);

    always_comb begin
        nxt_msd = cur_msd;
        nxt_lsd = cur_lsd;
        wrap    = 1'b0;
        if (!down) begin
            if (at_max) begin
                wrap    = 1'b1;
                nxt_msd = min_msd;
                nxt_lsd = min_lsd;
            end else if (cur_lsd == BCD_MAX_DIGIT) begin
                nxt_lsd = 4'd0;
                nxt_msd = cur_msd + 4'd1;
            end else begin
                nxt_lsd = cur_lsd + 4'd1;
            end
        end else begin
            if (at_min) begin
                wrap    = 1'b1;
                nxt_msd = max_msd;
                nxt_lsd = max_lsd;
            end else if (cur_lsd == 4'd0) begin
                nxt_lsd = BCD_MAX_DIGIT;
                nxt_msd = cur_msd - 4'd1;
            end else begin
                nxt_lsd = cur_lsd - 4'd1;
            end
        end
    end

endmodule

// File: rtl/cont_bcd_mod.sv
// Two-digit BCD modulo counter with up/down count, clear, checked preset
// and single-cycle carry/borrow pulses for cascading clock stages.
// Ports: cbm_clock/cbm_reset, cbm_enable/cbm_down count control,
//        cbm_clear, cbm_load + cbm_load_msd/lsd preset, cbm_msd/lsd value,
//        cbm_carry/cbm_borrow wrap pulses, cbm_load_err rejected preset.
module cont_bcd_mod
    import relogio_pkg::*;
#(
    parameter int MODULUS   = 60,
    parameter int MIN_VALUE = 0
) (
    input  logic       cbm_clock,
    input  logic       cbm_reset,
    input  logic       cbm_enable,
    input  logic       cbm_down,
    input  logic       cbm_clear,
    input  logic       cbm_load,
    input  logic [3:0] cbm_load_lsd,
    input  logic [3:0] cbm_load_msd,
    output logic [3:0] cbm_lsd,
    output logic [3:0] cbm_msd,
    output logic       cbm_carry,
    output logic       cbm_borrow,
    output logic       cbm_load_err
);

    localparam int MAX_VALUE = MIN_VALUE + MODULUS - 1;

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("cont_bcd_mod: MODULUS must be 2..100");
    end
    if (MIN_VALUE < 0 || MAX_VALUE > 99) begin : g_bad_range
        $error("cont_bcd_mod: range must lie within 0..99");
    end

    localparam bcd_digit_t MIN_MSD = 4'(MIN_VALUE / 10);
    localparam bcd_digit_t MIN_LSD = 4'(MIN_VALUE % 10);
    localparam bcd_digit_t MAX_MSD = 4'(MAX_VALUE / 10);
    localparam bcd_digit_t MAX_LSD = 4'(MAX_VALUE % 10);
    localparam logic [8:0] MIN_V9  = 9'(MIN_VALUE);
    localparam logic [7:0] MAX_V8  = 8'(MAX_VALUE);

    bcd_digit_t lsd_q, lsd_d;
    bcd_digit_t msd_q, msd_d;
    logic       load_err_q, load_err_d;

    bcd_digit_t step_msd;
    bcd_digit_t step_lsd;
    logic       step_wrap;

    logic [7:0] preset;
    logic [8:0] preset_off;
    logic       preset_ok;

    cbm_passo_bcd u_passo (
        .cur_msd (msd_q),
        .cur_lsd (lsd_q),
        .down    (cbm_down),
        .min_msd (MIN_MSD),
        .min_lsd (MIN_LSD),
        .max_msd (MAX_MSD),
        .max_lsd (MAX_LSD),
        .nxt_msd (step_msd),
        .nxt_lsd (step_lsd),
        .wrap    (step_wrap)
    );

    // Lower bound via the sign of a widened difference so that a zero
    // minimum does not turn into an always-true unsigned compare.
    assign preset     = bcd_pair_to_int(cbm_load_msd, cbm_load_lsd);
    assign preset_off = {1'b0, preset} - MIN_V9;
    assign preset_ok  = bcd_is_valid(cbm_load_msd)
                      && bcd_is_valid(cbm_load_lsd)
                      && !preset_off[8]
                      && (preset <= MAX_V8);

    always_comb begin
        lsd_d      = lsd_q;
        msd_d      = msd_q;
        load_err_d = 1'b0;
        if (cbm_clear) begin
            lsd_d = MIN_LSD;
            msd_d = MIN_MSD;
        end else if (cbm_load) begin
            if (preset_ok) begin
                lsd_d = cbm_load_lsd;
                msd_d = cbm_load_msd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (cbm_enable) begin
            lsd_d = step_lsd;
            msd_d = step_msd;
        end
    end

    always_ff @(posedge cbm_clock or posedge cbm_reset) begin
        if (cbm_reset) begin
            lsd_q      <= MIN_LSD;
            msd_q      <= MIN_MSD;
            load_err_q <= 1'b0;
        end else begin
            lsd_q      <= lsd_d;
            msd_q      <= msd_d;
            load_err_q <= load_err_d;
        end
    end

    // Wrap pulses only when the step is actually taken this cycle.
    assign cbm_carry  = cbm_enable & ~cbm_down & step_wrap
                      & ~cbm_clear & ~cbm_load;
    assign cbm_borrow = cbm_enable & cbm_down & step_wrap
                      & ~cbm_clear & ~cbm_load;

    assign cbm_lsd      = lsd_q;
    assign cbm_msd      = msd_q;
    assign cbm_load_err = load_err_q;

endmodule

// File: tb/tb_cont_bcd_mod.sv
// Randomised and directed bench for cont_bcd_mod: three ranges share one
// stimulus bus, plus a 60-into-24 cascade, all checked against a model.
module tb_cont_bcd_mod;

    localparam int MINS[3] = '{0, 1, 0};
    localparam int MODS[3] = '{60, 12, 24};

    logic       clk;
    logic       rst;
    logic       en, dn, clr, ld;
    logic [3:0] pl, pm;
    logic [3:0] lsd[3];
    logic [3:0] msd[3];
    logic       cy[3];
    logic       bw[3];
    logic       le[3];

    logic       cas_en;
    logic [3:0] m_lsd, m_msd, h_lsd, h_msd;
    logic       m_cy, m_bw, m_le, h_cy, h_bw, h_le;

    int total;
    int bad;
    int v[3];
    bit err[3];
    int cas_n;

    cont_bcd_mod #(.MODULUS(60), .MIN_VALUE(0)) u_a (
        .cbm_clock(clk), .cbm_reset(rst), .cbm_enable(en), .cbm_down(dn),
        .cbm_clear(clr), .cbm_load(ld), .cbm_load_lsd(pl), .cbm_load_msd(pm),
        .cbm_lsd(lsd[0]), .cbm_msd(msd[0]), .cbm_carry(cy[0]),
        .cbm_borrow(bw[0]), .cbm_load_err(le[0]));

    cont_bcd_mod #(.MODULUS(12), .MIN_VALUE(1)) u_b (
        .cbm_clock(clk), .cbm_reset(rst), .cbm_enable(en), .cbm_down(dn),
        .cbm_clear(clr), .cbm_load(ld), .cbm_load_lsd(pl), .cbm_load_msd(pm),
        .cbm_lsd(lsd[1]), .cbm_msd(msd[1]), .cbm_carry(cy[1]),
        .cbm_borrow(bw[1]), .cbm_load_err(le[1]));

    cont_bcd_mod #(.MODULUS(24), .MIN_VALUE(0)) u_c (
        .cbm_clock(clk), .cbm_reset(rst), .cbm_enable(en), .cbm_down(dn),
        .cbm_clear(clr), .cbm_load(ld), .cbm_load_lsd(pl), .cbm_load_msd(pm),
        .cbm_lsd(lsd[2]), .cbm_msd(msd[2]), .cbm_carry(cy[2]),
        .cbm_borrow(bw[2]), .cbm_load_err(le[2]));

    cont_bcd_mod #(.MODULUS(60), .MIN_VALUE(0)) u_min (
        .cbm_clock(clk), .cbm_reset(rst), .cbm_enable(cas_en),
        .cbm_down(1'b0), .cbm_clear(1'b0), .cbm_load(1'b0),
        .cbm_load_lsd(4'd0), .cbm_load_msd(4'd0),
        .cbm_lsd(m_lsd), .cbm_msd(m_msd), .cbm_carry(m_cy),
        .cbm_borrow(m_bw), .cbm_load_err(m_le));

    cont_bcd_mod #(.MODULUS(24), .MIN_VALUE(0)) u_hour (
        .cbm_clock(clk), .cbm_reset(rst), .cbm_enable(m_cy),
        .cbm_down(1'b0), .cbm_clear(1'b0), .cbm_load(1'b0),
        .cbm_load_lsd(4'd0), .cbm_load_msd(4'd0),
        .cbm_lsd(h_lsd), .cbm_msd(h_msd), .cbm_carry(h_cy),
        .cbm_borrow(h_bw), .cbm_load_err(h_le));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int bcd(input int x);
        return (x / 10) * 16 + (x % 10);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            v[i]   = MINS[i];
            err[i] = 1'b0;
        end
        cas_n = 0;
    endtask

    task automatic model_step();
        int p;
        for (int i = 0; i < 3; i++) begin
            err[i] = 1'b0;
            p = int'(pm) * 10 + int'(pl);
            if (clr) begin
                v[i] = MINS[i];
            end else if (ld) begin
                if (pm <= 9 && pl <= 9 && p >= MINS[i]
                    && p <= MINS[i] + MODS[i] - 1)
                    v[i] = p;
                else
                    err[i] = 1'b1;
            end else if (en) begin
                if (!dn)
                    v[i] = MINS[i] + (v[i] - MINS[i] + 1) % MODS[i];
                else
                    v[i] = MINS[i]
                         + (v[i] - MINS[i] - 1 + MODS[i]) % MODS[i];
            end
        end
        if (cas_en) cas_n++;
    endtask

    task automatic comb_check();
        int mx;
        bit quiet;
        quiet = en && !clr && !ld;
        for (int i = 0; i < 3; i++) begin
            mx = MINS[i] + MODS[i] - 1;
            chk($sformatf("carry%0d", i), int'(cy[i]),
                int'(quiet && !dn && v[i] == mx));
            chk($sformatf("borrow%0d", i), int'(bw[i]),
                int'(quiet && dn && v[i] == MINS[i]));
        end
        chk("cas_mcarry", int'(m_cy), int'(cas_en && cas_n % 60 == 59));
        chk("cas_hcarry", int'(h_cy),
            int'(cas_en && cas_n % 1440 == 1439));
    endtask

    task automatic reg_check();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("value%0d", i), int'({msd[i], lsd[i]}),
                bcd(v[i]));
            chk($sformatf("lsd_ok%0d", i), int'(lsd[i] <= 4'd9), 1);
            chk($sformatf("load_err%0d", i), int'(le[i]), int'(err[i]));
        end
        chk("cas_min", int'({m_msd, m_lsd}), bcd(cas_n % 60));
        chk("cas_hour", int'({h_msd, h_lsd}), bcd((cas_n / 60) % 24));
    endtask

    task automatic do_cycle();
        @(negedge clk);
        comb_check();
        @(posedge clk);
        model_step();
        #1;
        reg_check();
    endtask

    task automatic drive(input bit e, input bit d, input bit c,
                         input bit l, input int m, input int s);
        en  = e;
        dn  = d;
        clr = c;
        ld  = l;
        pm  = 4'(m);
        pl  = 4'(s);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cas_en = 1'b0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        reg_check();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        drive(1, 0, 0, 0, 0, 0);
        repeat (60) do_cycle();
        drive(1, 1, 0, 0, 0, 0);
        do_cycle();
        drive(1, 0, 0, 0, 0, 0);
        do_cycle();

        drive(0, 0, 0, 1, 2, 3);
        do_cycle();
        drive(0, 0, 0, 1, 2, 4);
        do_cycle();
        drive(0, 0, 0, 1, 1, 10);
        do_cycle();
        drive(0, 0, 0, 0, 0, 0);
        do_cycle();

        drive(0, 0, 0, 1, 5, 9);
        do_cycle();
        drive(1, 0, 0, 1, 3, 0);
        do_cycle();
        drive(0, 0, 1, 1, 4, 5);
        do_cycle();

        drive(0, 0, 0, 1, 3, 7);
        do_cycle();
        drive(1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        model_reset();
        #1;
        reg_check();
        #1 rst = 1'b0;
        do_cycle();

        repeat (400) begin
            int r;
            r   = $urandom_range(0, 99);
            clr = (r < 5);
            ld  = (r >= 5 && r < 20);
            en  = ($urandom_range(0, 3) != 0);
            dn  = 1'($urandom_range(0, 1));
            pm  = 4'($urandom_range(0, 10));
            pl  = 4'($urandom_range(0, 10));
            do_cycle();
        end

        drive(0, 0, 0, 0, 0, 0);
        cas_en = 1'b1;
        repeat (1440) do_cycle();
        cas_en = 1'b0;
        chk("cas_min_home", int'({m_msd, m_lsd}), 0);
        chk("cas_hour_home", int'({h_msd, h_lsd}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
